branch_history_table: RTL



---
 rtl/branch_history_table.sv | 83 ++++++++
 1 files changed

// File: rtl/branch_history_table.sv
// branch_history_table: 2-bit saturating-counter branch predictor indexed by PC.
// Optional statistics counters are enabled by defining BHT_STATS_EN.
module branch_history_table #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ready,
  input  logic        lookup_valid,
  input  logic [31:0] lookup_pc,
  output logic        pred_valid,
  output logic        pred_taken,
  input  logic        update_valid,
  input  logic [31:0] update_pc,
  input  logic        update_pred,
  input  logic        branch_taken,
  output logic        mispredict
`ifdef BHT_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);
  localparam int DEPTH = 1 << INDEX_BITS;
  typedef enum logic {S_INIT, S_RUN} state_t;
  state_t r_state, w_next;
  logic [INDEX_BITS-1:0] r_ptr;
  logic [1:0] r_table [DEPTH];
  logic [INDEX_BITS-1:0] w_lidx, w_uidx;
  logic [1:0] w_cur, w_trained;
  logic w_run, w_upd, w_miss, w_unused;
  assign w_lidx = lookup_pc[INDEX_BITS+1:2];
  assign w_uidx = update_pc[INDEX_BITS+1:2];
  assign w_unused = ^{lookup_pc[31:INDEX_BITS+2], lookup_pc[1:0], update_pc[31:INDEX_BITS+2], update_pc[1:0]};
  assign w_run = (r_state == S_RUN);
  assign w_upd = w_run && update_valid;
  assign w_miss = update_pred != branch_taken;
  assign w_cur = r_table[w_uidx];
  assign ready = w_run;
  always_comb begin
    w_next = (r_state == S_INIT && (&r_ptr)) ? S_RUN : r_state;
    w_trained = branch_taken ? ((&w_cur) ? w_cur : w_cur + 2'd1)
                             : ((|w_cur) ? w_cur - 2'd1 : w_cur);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_INIT;
      r_ptr <= '0;
    end else begin
      r_state <= w_next;
      if (!w_run) r_ptr <= r_ptr + 1'b1;
    end
  end
  // Table has no reset of its own: the INIT sweep rewrites every entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!w_run) r_table[r_ptr] <= 2'b01;
      else if (update_valid) r_table[w_uidx] <= w_trained;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      mispredict <= 1'b0;
    end else begin
      pred_valid <= w_run && lookup_valid;
      if (w_run && lookup_valid) pred_taken <= r_table[w_lidx][1];
      mispredict <= w_upd && w_miss;
    end
  end
`ifdef BHT_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches <= '0;
      stat_mispredicts <= '0;
    end else if (w_upd) begin
      stat_branches <= stat_branches + 32'd1;
      if (w_miss) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif
endmodule
